filt_decim_rs: RTL
==================

# filt_decim_rs

Decimating output stage placed directly downstream of `filt_fir`. It keeps one of every `gp_decim` enabled FIR output samples. It reduces the full-precision FIR result to the system output word by dropping `gp_shift` LSBs with optional rounding, then saturating to `gp_oup_width`. Each kept sample is presented with a one-cycle valid strobe and a sticky overflow flag.

## Interface
Parameters:
- `gp_inp_width`, default 32: signed input width; matches `filt_fir` `o_data` width.
- `gp_oup_width`, default 16: signed output width; must be ≤ `gp_inp_width` − `gp_shift`.
- `gp_shift`, default 12: number of LSBs dropped (0 allowed).
- `gp_decim`, default 4: decimation factor, ≥ 1.

Ports:
- `i_clk`, in, 1: clock. Everything registers on the rising edge.
- `i_rst`, in, 1: reset. Asynchronous and active-high.
- `i_ena`, in, 1: sample enable. An input sample is consumed on each edge where it is high.
- `i_data`, in, `gp_inp_width`: signed FIR output sample.
- `i_ovf_clr`, in, 1: synchronous clear of `o_ovf`.
- `o_data`, out, `gp_oup_width`: signed decimated, rounded and saturated sample. Holds its value between strobes.
- `o_valid`, out, 1: one-cycle strobe. High when `o_data` carries a new sample.
- `o_ovf`, out, 1: sticky flag. Set when any kept sample saturated.

## Operation
- Phase counter `ph` runs over 0..`gp_decim`−1.
  - It advances on each edge with `i_ena`=1 and wraps from `gp_decim`−1 to 0.
  - It freezes when `i_ena`=0.
  - With `gp_decim`=1 it is constantly 0.
- Keep condition: `i_ena`=1 and `ph`=0. The first enabled sample after reset is always kept.
- Stage 1, on a keep edge:
  - `acc` = sign-extend(`i_data`) to `gp_inp_width`+1 bits, plus rounding offset R.
  - `acc` is then arithmetically shifted right by `gp_shift`.
  - R is defined under Configuration.
  - The extra bit guarantees the rounding add never wraps.
  - A valid bit `v1` is set for one cycle.
- Stage 2, on the edge where `v1`=1:
  - Saturate `acc` to the signed `gp_oup_width` range [−2^(W−1), 2^(W−1)−1].
  - Register the result into `o_data` and pulse `o_valid`.
  - If clipping occurred, set `o_ovf`.
- The pipeline advances every clock, independent of `i_ena`. Only capture is gated.
- `o_ovf`:
  - Set by saturation.
  - Cleared by `i_ovf_clr`=1.
  - If both happen on the same edge, set wins.
- Reset: `ph`=0, `acc`=0, `v1`=0, `o_data`=0, `o_valid`=0, `o_ovf`=0.
  - Reset may assert mid-frame. Any in-flight sample is discarded and no strobe follows.
  - After deassertion, the next enabled sample is kept.

## Timing
- Latency: a sample kept at edge N gives `o_valid`=1 and the new `o_data` after edge N+1, i.e. 2 register stages.
- `o_valid` is high for exactly one cycle per kept sample.
- Throughput is one output per `gp_decim` enabled inputs. Strobes never overlap for any `gp_decim` ≥ 1.
- With `gp_decim`=1 and `i_ena` continuously high, `o_valid` is continuously high.
- `i_ovf_clr` takes effect at the next edge.

## Configuration
- Macro: `FILT_DECIM_ROUND_EN`.
- Defined: round-half-up. R = 2^(`gp_shift`−1) when `gp_shift` > 0, else 0.
- Undefined: truncation toward −∞. R = 0, and the adder is removed.
- Saturation, decimation and overflow behaviour are identical in both builds.

## Test plan
All scenarios use defaults: 32 → 16 bits, `gp_shift`=12, `gp_decim`=4.
1. Reset: hold `i_rst`=1 with random `i_data` and `i_ena` toggling. Required: `o_data`=0, `o_valid`=0, `o_ovf`=0 throughout.
2. Decimation:
   - Stimulus: `i_ena`=1 continuously, `i_data` = k·4096 for k=0..15 on edges 0..15.
   - Required: `o_valid` only after edges 1, 5, 9, 13, with `o_data` = 0, 4, 8, 12.
3. Rounding, one kept sample per value:
   - `i_data` = 2048: `o_data` = 1 with the macro, 0 without.
   - `i_data` = −2048: `o_data` = 0 with the macro, −1 without.
   - `i_data` = 6143: `o_data` = 1 in both builds.
4. Saturation:
   - `i_data` = 0x7FFFFFFF: `o_data` = 32767 and `o_ovf`=1.
   - `i_data` = 0x80000000: `o_data` = −32768.
   - Pulse `i_ovf_clr` with an in-range sample: `o_ovf` = 0.
   - Pulse `i_ovf_clr` on the same edge as a saturating stage-2 sample: `o_ovf` stays 1.
5. Enable gating: drop `i_ena` for 3 cycles after the second sample of a frame. Required: `ph` freezes, and the next strobe comes 4 enabled samples after the previous strobe, never 4 clocks.
6. Reset mid-operation:
   - Assert `i_rst` on the cycle after a keep edge. Required: no `o_valid` pulse for that sample.
   - After release, the first enabled sample (value 8192) produces `o_data` = 2 two edges later.

Source files
------------

// File: rtl/filt_decim_rs.sv
// filt_decim_rs -- decimating output stage for filt_fir.
//
// Keeps one of every gp_decim enabled input samples, drops gp_shift LSBs
// (round-half-up when FILT_DECIM_ROUND_EN is defined, truncation toward
// -inf otherwise), saturates to gp_oup_width and presents each kept sample
// with a one-cycle strobe. Two register stages: capture/shift, then
// saturate/output.
//
// Build option:
//   FILT_DECIM_ROUND_EN  defined   -> add 2^(gp_shift-1) before the shift
//                        undefined -> plain arithmetic shift, no adder
//
// Ports:
//   i_clk      in   1             rising-edge clock
//   i_rst      in   1             asynchronous active-high reset
//   i_ena      in   1             input sample enable
//   i_data     in   gp_inp_width  signed FIR sample
//   i_ovf_clr  in   1             synchronous clear of o_ovf
//   o_data     out  gp_oup_width  signed decimated/rounded/saturated sample
//   o_valid    out  1             one-cycle strobe for new o_data
//   o_ovf      out  1             sticky saturation flag (set wins over clear)

module filt_decim_rs #(
  parameter int unsigned gp_inp_width = 32,
  parameter int unsigned gp_oup_width = 16,
  parameter int unsigned gp_shift     = 12,
  parameter int unsigned gp_decim     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ena,
  input  logic [gp_inp_width-1:0] i_data,
  input  logic                    i_ovf_clr,
  output logic [gp_oup_width-1:0] o_data,
  output logic                    o_valid,
  output logic                    o_ovf
);

  // One guard bit so the rounding add can never wrap.
  localparam int unsigned AW = gp_inp_width + 1;
  localparam int unsigned PW = (gp_decim > 1) ? $clog2(gp_decim) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(gp_decim - 1);

  // Saturation bounds expressed in the accumulator width.
  localparam logic [AW-1:0] SAT_MAX =
    {{(AW - gp_oup_width + 1){1'b0}}, {(gp_oup_width - 1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN =
    {{(AW - gp_oup_width + 1){1'b1}}, {(gp_oup_width - 1){1'b0}}};

  logic [PW-1:0]           ph;
  logic                    keep;
  logic signed [AW-1:0]    ext;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    shifted;
  logic signed [AW-1:0]    acc;
  logic                    v1;
  logic [gp_oup_width-1:0] sat_data;
  logic                    clip;

  // ---------------------------------------------------------------------
  // Phase counter: advances only on enabled samples, wraps at gp_decim-1.
  // With gp_decim = 1, PH_LAST is 0 so the counter stays at 0.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ph <= '0;
    end else if (i_ena) begin
      ph <= (ph == PH_LAST) ? '0 : ph + PW'(1);
    end
  end

  assign keep = i_ena && (ph == '0);

  // ---------------------------------------------------------------------
  // Stage 1: sign-extend, optional rounding offset, arithmetic shift.
  // ---------------------------------------------------------------------
  assign ext = {i_data[gp_inp_width-1], i_data};

`ifdef FILT_DECIM_ROUND_EN
  localparam int unsigned RSH = (gp_shift > 0) ? gp_shift - 1 : 0;
  localparam logic [AW-1:0] RND =
    (gp_shift > 0) ? ({{(AW - 1){1'b0}}, 1'b1} << RSH) : '0;
  assign sum = ext + $signed(RND);
`else
  assign sum = ext;
`endif

  assign shifted = sum >>> gp_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= keep;
      if (keep) begin
        acc <= shifted;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: saturate to the output range.
  // ---------------------------------------------------------------------
  always_comb begin
    sat_data = acc[gp_oup_width-1:0];
    clip     = 1'b0;
    if (acc > $signed(SAT_MAX)) begin
      sat_data = SAT_MAX[gp_oup_width-1:0];
      clip     = 1'b1;
    end else if (acc < $signed(SAT_MIN)) begin
      sat_data = SAT_MIN[gp_oup_width-1:0];
      clip     = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= v1;
      if (v1) begin
        o_data <= sat_data;
      end
      // A saturating sample on the same edge as a clear keeps the flag set.
      if (v1 && clip) begin
        o_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        o_ovf <= 1'b0;
      end
    end
  end

endmodule
